// File: rtl/washing_machine_pkg.sv
// Shared types for the washing machine controller: program state encoding.
package washing_machine_pkg;

  typedef enum logic [2:0] {
    CHECK_DOOR    = 3'd0,
    FILL_WATER    = 3'd1,
    ADD_DETERGENT = 3'd2,
    CYCLE         = 3'd3,
    DRAIN_WATER   = 3'd4,
    SPIN          = 3'd5
  } state_e;

endpackage : washing_machine_pkg

// File: rtl/washing_machine_if.sv
// Sensor/timer events into the controller and actuator/status outputs back out.
interface washing_machine_if;

  logic door_close;
  logic start;
  logic filled;
  logic detergent_added;
  logic cycle_timeout;
  logic drained;
  logic spin_timeout;

  logic door_lock;
  logic motor_on;
  logic fill_value_on;
  logic drain_value_on;
  logic done;
  logic soap_wash;
  logic water_wash;

  modport master (
    input  door_close, start, filled, detergent_added,
           cycle_timeout, drained, spin_timeout,
    output door_lock, motor_on, fill_value_on, drain_value_on,
           done, soap_wash, water_wash
  );

  modport slave (
    output door_close, start, filled, detergent_added,
           cycle_timeout, drained, spin_timeout,
    input  door_lock, motor_on, fill_value_on, drain_value_on,
           done, soap_wash, water_wash
  );

endinterface : washing_machine_if

// File: rtl/washing_machine.sv
// Wash program sequencer: soap pass then rinse pass, ending with a spin.
// The soap_wash/water_wash flags select which pass the shared states belong to.
module washing_machine
  import washing_machine_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  washing_machine_if.master wm
);

  state_e state_q, state_d;
  logic   soap_wash_q, soap_wash_d;
  logic   water_wash_q, water_wash_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CHECK_DOOR;
      soap_wash_q  <= 1'b0;
      water_wash_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      soap_wash_q  <= soap_wash_d;
      water_wash_q <= water_wash_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    soap_wash_d  = soap_wash_q;
    water_wash_d = water_wash_q;
    unique case (state_q)
      CHECK_DOOR:
        if (wm.start && wm.door_close) state_d = FILL_WATER;
      FILL_WATER:
        if (wm.filled) state_d = soap_wash_q ? CYCLE : ADD_DETERGENT;
      ADD_DETERGENT:
        if (wm.detergent_added) begin
          state_d     = CYCLE;
          soap_wash_d = 1'b1;
        end
      CYCLE:
        if (wm.cycle_timeout) state_d = DRAIN_WATER;
      DRAIN_WATER:
        if (wm.drained) begin
          if (water_wash_q) begin
            state_d = SPIN;
          end else begin
            state_d      = FILL_WATER;
            water_wash_d = 1'b1;
          end
        end
      SPIN:
        if (wm.spin_timeout) begin
          state_d      = CHECK_DOOR;
          soap_wash_d  = 1'b0;
          water_wash_d = 1'b0;
        end
      default: state_d = CHECK_DOOR;
    endcase
  end

  always_comb begin
    wm.door_lock      = 1'b0;
    wm.motor_on       = 1'b0;
    wm.fill_value_on  = 1'b0;
    wm.drain_value_on = 1'b0;
    unique case (state_q)
      FILL_WATER: begin
        wm.door_lock     = 1'b1;
        wm.fill_value_on = 1'b1;
      end
      ADD_DETERGENT: wm.door_lock = 1'b1;
      CYCLE: begin
        wm.door_lock = 1'b1;
        wm.motor_on  = 1'b1;
      end
      DRAIN_WATER: begin
        wm.door_lock      = 1'b1;
        wm.drain_value_on = 1'b1;
      end
      SPIN: begin
        wm.door_lock      = 1'b1;
        wm.motor_on       = 1'b1;
        wm.drain_value_on = 1'b1;
      end
      default: ;
    endcase
    wm.done       = (state_q == SPIN) && wm.spin_timeout;
    wm.soap_wash  = soap_wash_q;
    wm.water_wash = water_wash_q;
  end

endmodule : washing_machine

// File: tb/tb_washing_machine.sv
// Directed and randomized checks of the washing machine controller against a
// program-step model: nine steps, each advanced by one named event.
module tb_washing_machine;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   m_step;

  washing_machine_if wm_if();

  washing_machine dut (
    .clk   (clk),
    .reset (reset),
    .wm    (wm_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step -> {door_lock, motor_on, fill_value_on, drain_value_on}
  function automatic logic [3:0] act_of(input int s);
    case (s)
      1, 5:    return 4'b1010;
      2:       return 4'b1000;
      3, 6:    return 4'b1100;
      4, 7:    return 4'b1001;
      8:       return 4'b1101;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic event_hit(input int s);
    case (s)
      0:       return wm_if.start && wm_if.door_close;
      1, 5:    return wm_if.filled;
      2:       return wm_if.detergent_added;
      3, 6:    return wm_if.cycle_timeout;
      4, 7:    return wm_if.drained;
      8:       return wm_if.spin_timeout;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] expected();
    logic done_e;
    done_e = (m_step == 8) && wm_if.spin_timeout;
    return {act_of(m_step), done_e, 1'(m_step >= 3), 1'(m_step >= 5)};
  endfunction

  task automatic check(input string tag);
    logic [6:0] obs, exp;
    obs = {wm_if.door_lock, wm_if.motor_on, wm_if.fill_value_on, wm_if.drain_value_on,
           wm_if.done, wm_if.soap_wash, wm_if.water_wash};
    exp = expected();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: step %0d observed %b expected %b", tag, m_step, obs, exp);
    end
  endtask

  // One clock: drive inputs after negedge, check before posedge, advance model.
  task automatic step_in(input logic rst_v, input logic d, input logic s, input logic f,
                         input logic da, input logic ct, input logic dr, input logic st,
                         input string tag);
    @(negedge clk);
    reset                  = rst_v;
    wm_if.door_close       = d;
    wm_if.start            = s;
    wm_if.filled           = f;
    wm_if.detergent_added  = da;
    wm_if.cycle_timeout    = ct;
    wm_if.drained          = dr;
    wm_if.spin_timeout     = st;
    if (!rst_v) m_step = 0;
    #1 check(tag);
    @(posedge clk);
    if (rst_v && event_hit(m_step)) m_step = (m_step + 1) % 9;
  endtask

  task automatic rand_in(input logic rst_v, input string tag);
    step_in(rst_v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_step = 0;
    reset  = 1'b0;
    {wm_if.door_close, wm_if.start, wm_if.filled, wm_if.detergent_added,
     wm_if.cycle_timeout, wm_if.drained, wm_if.spin_timeout} = '0;

    rand_in(1'b0, "reset");
    rand_in(1'b0, "reset");

    // Full program with single-cycle event pulses
    step_in(1, 0, 0, 0, 0, 0, 0, 0, "idle");
    step_in(1, 1, 1, 0, 0, 0, 0, 0, "start");
    step_in(1, 0, 0, 0, 0, 0, 1, 1, "fill_irrelevant");
    step_in(1, 0, 1, 0, 0, 0, 0, 0, "fill_hold");
    step_in(1, 1, 0, 1, 0, 0, 0, 0, "fill1");
    step_in(1, 0, 0, 0, 1, 0, 0, 0, "detergent");
    step_in(1, 0, 0, 0, 0, 1, 0, 0, "cycle1");
    step_in(1, 0, 0, 0, 0, 0, 1, 0, "drain1");
    step_in(1, 0, 0, 1, 0, 0, 0, 0, "fill2");
    step_in(1, 0, 0, 0, 0, 1, 0, 0, "cycle2");
    step_in(1, 0, 0, 0, 0, 0, 1, 0, "drain2");
    step_in(1, 0, 0, 0, 0, 0, 0, 0, "spin_wait");
    step_in(1, 0, 0, 0, 0, 0, 0, 1, "spin_done");
    step_in(1, 0, 0, 0, 0, 0, 0, 0, "back_idle");

    // Door open: start ignored
    for (int i = 0; i < 5; i++) step_in(1, 0, 1, 0, 0, 0, 0, 0, "door_open");

    // Reset while the drum turns in the soap cycle, then restart
    step_in(1, 1, 1, 0, 0, 0, 0, 0, "start_b");
    step_in(1, 0, 0, 1, 0, 0, 0, 0, "fill_b");
    step_in(1, 0, 0, 0, 1, 0, 0, 0, "det_b");
    step_in(1, 0, 0, 0, 0, 0, 0, 0, "cycle_b");
    step_in(0, 1, 1, 1, 1, 1, 1, 1, "mid_reset");
    step_in(1, 1, 1, 0, 0, 0, 0, 0, "restart");
    step_in(1, 0, 0, 1, 0, 0, 0, 0, "refill");
    step_in(1, 0, 0, 0, 0, 0, 0, 0, "re_detergent");

    // Start and door held through spin end: new program begins immediately
    step_in(1, 1, 1, 0, 1, 0, 0, 0, "hold_det");
    step_in(1, 1, 1, 0, 0, 1, 0, 0, "hold_cyc1");
    step_in(1, 1, 1, 0, 0, 0, 1, 0, "hold_drn1");
    step_in(1, 1, 1, 1, 0, 0, 0, 0, "hold_fill2");
    step_in(1, 1, 1, 0, 0, 1, 0, 0, "hold_cyc2");
    step_in(1, 1, 1, 0, 0, 0, 1, 0, "hold_drn2");
    step_in(1, 1, 1, 0, 0, 0, 0, 1, "hold_spin");
    step_in(1, 1, 1, 0, 0, 0, 0, 0, "rerun");
    step_in(1, 0, 0, 0, 0, 0, 0, 0, "rerun_fill");

    // Randomized inputs with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) rand_in(1'b0, "rand_reset");
      else                            rand_in(1'b1, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_washing_machine

// File: doc/washing_machine.md
# washing_machine

Control FSM for an automated washing machine. It sequences one complete wash program: door check, water fill, detergent, soap wash cycle, drain, rinse fill, rinse cycle, drain and spin. It sits between the appliance's sensor and timer inputs (door switch, level sensors, timers) and its actuators (door lock, motor, fill and drain valves). All timing is external; the block only reacts to one-cycle-or-longer event inputs.

## Interface
No parameters.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- door_close  in  1  1 = door is shut.
- start  in  1  user start request, level-sensitive.
- filled  in  1  water level reached.
- detergent_added  in  1  detergent dispensed.
- cycle_timeout  in  1  wash or rinse agitation timer expired.
- drained  in  1  drum empty.
- spin_timeout  in  1  spin timer expired.
- door_lock  out  1  door locked.
- motor_on  out  1  drum motor on.
- fill_value_on  out  1  fill valve open.
- drain_value_on  out  1  drain valve open.
- done  out  1  program-complete indication.
- soap_wash  out  1  status flag: soap wash pass has been done.
- water_wash  out  1  status flag: rinse pass is in progress or done.

## Operation
States: CHECK_DOOR (reset state), FILL_WATER, ADD_DETERGENT, CYCLE, DRAIN_WATER, SPIN.

Transitions:
- CHECK_DOOR → FILL_WATER when start && door_close. Otherwise hold.
- FILL_WATER, on filled:
  - → ADD_DETERGENT if soap_wash == 0.
  - → CYCLE if soap_wash == 1.
- ADD_DETERGENT → CYCLE on detergent_added. Set soap_wash = 1 on this edge.
- CYCLE → DRAIN_WATER on cycle_timeout.
- DRAIN_WATER, on drained:
  - → FILL_WATER if water_wash == 0. Set water_wash = 1 on this edge.
  - → SPIN if water_wash == 1.
- SPIN → CHECK_DOOR on spin_timeout. Clear soap_wash and water_wash on this edge.

Outputs are Moore-decoded from the state. Anything not listed is 0.
- FILL_WATER: door_lock, fill_value_on.
- ADD_DETERGENT: door_lock.
- CYCLE: door_lock, motor_on.
- DRAIN_WATER: door_lock, drain_value_on.
- SPIN: door_lock, motor_on, drain_value_on.
- done: Mealy output, = (state == SPIN) && spin_timeout, combinational.

Boundary conditions:
- Inputs that are irrelevant to the current state are ignored. This includes door_close going low while locked, and start asserted mid-program.
- If start and door_close are still high when SPIN returns to CHECK_DOOR, a new program starts on the next edge.
- Reset asserted mid-program: immediately return to CHECK_DOOR with both flags cleared and all outputs 0.

## Timing
- Reset values: state CHECK_DOOR; every output is 0.
- Each transition takes exactly 1 clock after its qualifying input is sampled high at a rising edge. Holding an input high longer has no further effect once the state has moved on.
- Flags update on the same edge as their transition and are visible during the next state.
- done asserts in the same cycle as spin_timeout. No registered latency.
- Inputs are assumed synchronous to clk. A pulse shorter than a clock period that misses a rising edge is not seen.

## Structure
- Shared package washing_machine_pkg: state enum (3-bit encoding, CHECK_DOOR = 0, then in the order listed above).
- Single module. State register, flag registers, next-state logic and output decode all inline. No sub-module is needed.

## Test plan
- Reset: hold reset=0 for 2 cycles with random inputs → state CHECK_DOOR, all outputs 0.
- Full program: door_close=1, start=1, then pulse in order filled, detergent_added, cycle_timeout, drained, filled, cycle_timeout, drained, spin_timeout. Required state sequence: FILL_WATER, ADD_DETERGENT, CYCLE, DRAIN_WATER, FILL_WATER, CYCLE, DRAIN_WATER, SPIN, CHECK_DOOR.
- Flags during the full program:
  - soap_wash = 1 from the first CYCLE onward.
  - water_wash = 1 from the second FILL_WATER onward.
  - done = 1 only during the spin_timeout cycle.
  - Both flags are 0 after returning to CHECK_DOOR.
- Door open: start=1 with door_close=0 for 5 cycles → remains in CHECK_DOOR, door_lock = 0.
- Reset mid-CYCLE: assert reset=0 while motor_on = 1 → outputs 0 immediately. Then releasing reset and restarting goes through ADD_DETERGENT again, because soap_wash was cleared.
- Irrelevant inputs: pulse drained and spin_timeout while in FILL_WATER → no state change, done stays 0.
